reg32_burst_reader: RTL and testbench
=====================================

Name: reg32_burst_reader

Overview:
- Read-side companion to the 16x32 register bank (reg32_ad).
- Accepts a burst-read command (start address, length) and walks the bank's flat data_out bus.
- Streams one 32-bit word per accepted beat over a valid/ready interface to a downstream consumer, e.g. a debug dump or a DMA.
- Sits between the register bank outputs and any consumer that needs sequential register contents.

Parameters:
- DATA_W, 32, width of one bank register.
- NUM_REGS, 16, number of bank registers; must be a power of 2.
- ADDR_W, 4, address width; equals log2(NUM_REGS).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- bank_data  input  NUM_REGS*DATA_W  flat concatenation of bank outputs; register i occupies bits [i*DATA_W +: DATA_W].
- rd_req  input  1  burst command strobe; sampled only in IDLE.
- rd_start  input  ADDR_W  first register address of the burst.
- rd_len  input  ADDR_W+1  number of words requested.
- busy  output  1  high in READ and DONE.
- out_valid  output  1  out_data/out_addr hold a valid word.
- out_ready  input  1  consumer accepts the word when high with out_valid.
- out_data  output  DATA_W  word read.
- out_addr  output  ADDR_W  address of out_data.
- rd_done  output  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Reset (synchronous, active-high; also mid-burst):
  - state=IDLE.
  - busy, out_valid and rd_done = 0.
  - out_data, out_addr, internal address and count = 0.
  - Any in-progress burst is abandoned with no rd_done.
- FSM states: IDLE, READ, DONE.
- IDLE:
  - On rd_req=1 with rd_len!=0, move to READ.
  - Effective length = min(rd_len, NUM_REGS).
  - On the same edge, load out_data=bank_data[rd_start], out_addr=rd_start, out_valid=1, remaining=len-1.
  - First word is valid on the cycle after rd_req (latency 1).
  - rd_req with rd_len=0 is ignored: no state change, no rd_done.
- READ:
  - A beat is accepted when out_valid && out_ready.
  - On an accepted beat with remaining>0:
    - next address = out_addr+1, wrapping modulo NUM_REGS (15 -> 0).
    - Reload out_data/out_addr from bank_data at the new address on the same edge; out_valid stays 1; remaining decrements.
    - Throughput is 1 word/cycle while out_ready is held high.
  - On an accepted beat with remaining==0: out_valid=0, move to DONE.
  - While out_valid && !out_ready, out_data and out_addr are held stable.
    - Bank changes are not reflected.
    - Data is sampled only at load time.
- DONE:
  - rd_done=1 for exactly one cycle, then move to IDLE.
  - busy drops in the IDLE cycle.
  - A new rd_req is accepted from that IDLE cycle onward; no back-to-back overlap with DONE.
- rd_req while busy=1 is ignored; it is neither queued nor an error.
- out_ready with out_valid=0 has no effect.
- out_valid never deasserts without an accepted beat, except on reset.

Optional Feature:
- READ_PARITY_EN defined:
  - Adds output port out_parity (1 bit) = XOR-reduction of out_data (even parity bit).
  - out_parity is registered on the same edge as out_data, held under backpressure, and reset to 0.
- Without the macro: port and logic are absent; the rest of the behaviour is identical.

Decomposition:
- Shared package reg32_pkg holds:
  - DATA_W, NUM_REGS, ADDR_W constants.
  - State enum rd_state_t {IDLE, READ, DONE}.
  - Bank-slice helper function bank_word(bus, addr).
- One natural sub-module: reg32_rd_mux, a combinational NUM_REGS:1 DATA_W-bit word select from bank_data by address.
- FSM, counters and output registers stay in the top module.

Test Plan:
- Reset values: hold reset 2 cycles, then release -> busy=0, out_valid=0, out_data=0, out_addr=0, rd_done=0.
- Basic burst: bank[i]=32'hA000_0000+i; rd_req, rd_start=2, rd_len=4, out_ready=1 -> out_valid on the next cycle; addr/data 2/A0000002, 3, 4, 5 on consecutive cycles; rd_done one cycle after beat 5.
- Wrap and clamp:
  - rd_start=14, rd_len=4 -> addresses 14, 15, 0, 1.
  - rd_len=20 -> 16 beats, 0..15 starting at rd_start=0.
  - rd_len=0 -> no out_valid, no rd_done.
- Backpressure: out_ready=0 for 3 cycles on beat 1, and bank[3] changes during the stall -> out_data/out_addr stable; beat count unchanged; bank[3] is sampled at its own load time.
- Ignored request and reset mid-burst:
  - rd_req during READ -> no effect on the beat sequence.
  - Assert reset after beat 2 of an 8-beat burst -> next cycle all outputs 0, no rd_done; a new burst then runs normally.
- Parity (READ_PARITY_EN): out_data=32'h0000_0007 -> out_parity=1; 32'h0000_0003 -> out_parity=0.

Source files
------------

// File: rtl/reg32_pkg.sv
// Shared constants, FSM state type and bank-slice helper for the reg32 burst reader.
package reg32_pkg;

  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 16;
  localparam int ADDR_W   = 4;

  typedef enum logic [1:0] {IDLE, READ, DONE} rd_state_t;

  function automatic logic [DATA_W-1:0] bank_word(
    input logic [NUM_REGS*DATA_W-1:0] bus,
    input logic [ADDR_W-1:0]          addr
  );
    return bus[addr*DATA_W +: DATA_W];
  endfunction

endpackage

// File: rtl/reg32_rd_mux.sv
// Combinational NUM_REGS:1 word select from the flat register-bank bus.
module reg32_rd_mux
  import reg32_pkg::*;
(
  input  logic [NUM_REGS*DATA_W-1:0] bank_data_i,
  input  logic [ADDR_W-1:0]          addr_i,
  output logic [DATA_W-1:0]          word_o
);

  assign word_o = bank_word(bank_data_i, addr_i);

endmodule

// File: rtl/reg32_burst_reader.sv
// Burst reader: streams consecutive bank registers over valid/ready.
// Optional even-parity output out_parity when READ_PARITY_EN is defined.
module reg32_burst_reader
  import reg32_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REGS*DATA_W-1:0] bank_data,
  input  logic                       rd_req,
  input  logic [ADDR_W-1:0]          rd_start,
  input  logic [ADDR_W:0]            rd_len,
  output logic                       busy,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          out_data,
  output logic [ADDR_W-1:0]          out_addr,
  output logic                       rd_done
`ifdef READ_PARITY_EN
  ,
  output logic                       out_parity
`endif
);

  localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(NUM_REGS);

  rd_state_t         state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] rem_q, rem_d;

  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_word;
  logic [ADDR_W:0]   len_sub;
  logic [ADDR_W-1:0] len_m1;

  // In IDLE the mux looks at the command address; afterwards at the next (wrapping) address.
  assign sel_addr = (state_q == IDLE) ? rd_start : addr_q + 1'b1;
  assign len_sub  = rd_len - 1'b1;
  assign len_m1   = (rd_len > LEN_MAX) ? ADDR_W'(NUM_REGS - 1) : len_sub[ADDR_W-1:0];

  reg32_rd_mux u_mux (
    .bank_data_i (bank_data),
    .addr_i      (sel_addr),
    .word_o      (sel_word)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d = state_q;
    data_d  = data_q;
    addr_d  = addr_q;
    valid_d = valid_q;
    rem_d   = rem_q;
    case (state_q)
      IDLE: begin
        if (rd_req && rd_len != '0) begin
          state_d = READ;
          data_d  = sel_word;
          addr_d  = rd_start;
          valid_d = 1'b1;
          rem_d   = len_m1;
        end
      end
      READ: begin
        if (valid_q && out_ready) begin
          if (rem_q != '0) begin
            data_d = sel_word;
            addr_d = sel_addr;
            rem_d  = rem_q - 1'b1;
          end else begin
            valid_d = 1'b0;
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      data_q  <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      rem_q   <= rem_d;
    end
  end

`ifdef READ_PARITY_EN
  logic parity_q;

  // Parity tracks the data register, so it holds under backpressure as data does.
  always_ff @(posedge clk) begin
    if (reset) parity_q <= 1'b0;
    else       parity_q <= ^data_d;
  end

  assign out_parity = parity_q;
`endif

  assign busy      = (state_q != IDLE);
  assign rd_done   = (state_q == DONE);
  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_addr  = addr_q;

endmodule

// File: tb/tb_reg32_burst_reader.sv
// Self-checking bench for reg32_burst_reader: directed and randomized bursts against a queue model.
module tb_reg32_burst_reader;
  import reg32_pkg::*;

  logic                       clk = 1'b0;
  logic                       reset = 1'b1;
  logic [NUM_REGS*DATA_W-1:0] bank_data;
  logic                       rd_req = 1'b0;
  logic [ADDR_W-1:0]          rd_start = '0;
  logic [ADDR_W:0]            rd_len = '0;
  logic                       busy;
  logic                       out_valid;
  logic                       out_ready = 1'b0;
  logic [DATA_W-1:0]          out_data;
  logic [ADDR_W-1:0]          out_addr;
  logic                       rd_done;
`ifdef READ_PARITY_EN
  logic                       out_parity;
`endif

  logic [DATA_W-1:0] bank [NUM_REGS];
  int checks = 0;
  int errors = 0;

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_pack
    assign bank_data[g*DATA_W +: DATA_W] = bank[g];
  end

  reg32_burst_reader dut (
    .clk       (clk),
    .reset     (reset),
    .bank_data (bank_data),
    .rd_req    (rd_req),
    .rd_start  (rd_start),
    .rd_len    (rd_len),
    .busy      (busy),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_addr  (out_addr),
    .rd_done   (rd_done)
`ifdef READ_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " valid"}, 32'(out_valid), 32'd0);
    chk({tag, " done"}, 32'(rd_done), 32'd0);
  endtask

  task automatic check_beat(input string tag, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    chk({tag, " valid"}, 32'(out_valid), 32'd1);
    chk({tag, " busy"}, 32'(busy), 32'd1);
    chk({tag, " done"}, 32'(rd_done), 32'd0);
    chk({tag, " addr"}, 32'(out_addr), 32'(a));
    chk({tag, " data"}, out_data, d);
`ifdef READ_PARITY_EN
    chk({tag, " parity"}, 32'(out_parity), 32'(^d));
`endif
  endtask

  // Model: a burst is the address list (start+k) mod NUM_REGS for k < min(len, NUM_REGS);
  // each word is the bank contents at that address (bank held stable for these bursts).
  task automatic run_burst(input int start, input int len, input int ready_pct, input bit noise);
    logic [ADDR_W-1:0] exp_q[$];
    int n, idx, cyc;
    n = (len > NUM_REGS) ? NUM_REGS : len;
    for (int k = 0; k < n; k++) exp_q.push_back(ADDR_W'((start + k) % NUM_REGS));
    @(negedge clk);
    rd_req = 1'b1; rd_start = ADDR_W'(start); rd_len = (ADDR_W+1)'(len); out_ready = 1'b0;
    @(negedge clk);
    rd_req = 1'b0;
    if (n == 0) begin
      for (int c = 0; c < 3; c++) begin
        check_idle("zero_len");
        @(negedge clk);
      end
      return;
    end
    idx = 0;
    cyc = 0;
    while (idx < n && cyc < 2000) begin
      check_beat("beat", exp_q[idx], bank[exp_q[idx]]);
      out_ready = ($urandom_range(99) < ready_pct);
      rd_req    = noise ? 1'($urandom_range(1)) : 1'b0;
      rd_start  = ADDR_W'($urandom);
      rd_len    = (ADDR_W+1)'($urandom_range(1, 20));
      if (out_ready) idx++;
      cyc++;
      @(negedge clk);
    end
    chk("beat_count", idx, n);
    rd_req = 1'b0;
    out_ready = 1'($urandom_range(1));
    chk("done valid", 32'(out_valid), 32'd0);
    chk("done pulse", 32'(rd_done), 32'd1);
    chk("done busy", 32'(busy), 32'd1);
    @(negedge clk);
    out_ready = 1'b0;
    check_idle("after_done");
  endtask

  initial begin
    for (int i = 0; i < NUM_REGS; i++) bank[i] = 32'hA000_0000 + i;

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_idle("reset");
    chk("reset data", out_data, 32'd0);
    chk("reset addr", 32'(out_addr), 32'd0);
`ifdef READ_PARITY_EN
    chk("reset parity", 32'(out_parity), 32'd0);
`endif
    @(negedge clk);
    check_idle("post_reset");

    // Basic, wrap, clamp, zero length, ignored request during READ
    run_burst(2, 4, 100, 1'b0);
    run_burst(14, 4, 100, 1'b0);
    run_burst(0, 20, 100, 1'b0);
    run_burst(5, 0, 100, 1'b0);
    run_burst(7, 6, 100, 1'b1);

    // Backpressure with bank[3] changing during the stall on the first beat
    @(negedge clk);
    rd_req = 1'b1; rd_start = 4'd2; rd_len = 5'd3; out_ready = 1'b0;
    @(negedge clk);
    rd_req = 1'b0;
    for (int s = 0; s < 3; s++) begin
      check_beat("stall", 4'd2, 32'hA000_0002);
      if (s == 1) bank[3] = 32'hDEAD_BEEF;
      @(negedge clk);
    end
    check_beat("stall_end", 4'd2, 32'hA000_0002);
    out_ready = 1'b1;
    @(negedge clk);
    check_beat("bp beat2", 4'd3, 32'hDEAD_BEEF);
    @(negedge clk);
    check_beat("bp beat3", 4'd4, 32'hA000_0004);
    @(negedge clk);
    chk("bp done", 32'(rd_done), 32'd1);
    chk("bp valid", 32'(out_valid), 32'd0);
    out_ready = 1'b0;
    bank[3] = 32'hA000_0003;
    @(negedge clk);
    check_idle("bp idle");

    // Reset after beat 2 of an 8-beat burst
    @(negedge clk);
    rd_req = 1'b1; rd_start = 4'd5; rd_len = 5'd8; out_ready = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
    check_beat("rst beat1", 4'd5, 32'hA000_0005);
    @(negedge clk);
    check_beat("rst beat2", 4'd6, 32'hA000_0006);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b0;
    check_idle("mid_reset");
    chk("mid_reset data", out_data, 32'd0);
    chk("mid_reset addr", 32'(out_addr), 32'd0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check_idle("post_mid_reset");
    end
    run_burst(9, 5, 70, 1'b0);

    // Randomized bursts over random bank contents
    for (int t = 0; t < 20; t++) begin
      for (int i = 0; i < NUM_REGS; i++) bank[i] = $urandom;
      run_burst(int'($urandom_range(15)), int'($urandom_range(20)),
                int'($urandom_range(30, 100)), 1'($urandom_range(1)));
    end

`ifdef READ_PARITY_EN
    bank[0] = 32'h0000_0007;
    bank[1] = 32'h0000_0003;
    @(negedge clk);
    rd_req = 1'b1; rd_start = 4'd0; rd_len = 5'd2; out_ready = 1'b0;
    @(negedge clk);
    rd_req = 1'b0;
    chk("parity 7", 32'(out_parity), 32'd1);
    out_ready = 1'b1;
    @(negedge clk);
    chk("parity 3", 32'(out_parity), 32'd0);
    @(negedge clk);
    out_ready = 1'b0;
    @(negedge clk);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
